nios_accelerometer_button_debounce: RTL and testbench
=====================================================

// Module: nios_accelerometer_button_debounce
// PURPOSE
//  Conditions raw push-button inputs before they reach the button PIO's 4-bit
//  in_port. Each bit passes through a two-flop synchroniser and a per-bit
//  debounce counter, and is delivered as a clean, glitch-free level.
//  Optional registered press/release event pulses are available for the
//  interrupt and edge logic.
// PARAMETERS
//  WIDTH            4       number of button bits
//  DEBOUNCE_CYCLES  500000  cycles a new level must hold before acceptance (10 ms @ 50 MHz); >=1
//  CNT_W            19      counter width; 2**CNT_W >= DEBOUNCE_CYCLES
//  IDLE_LEVEL       1'b1    released level of every button (DE-board KEYs are active-low)
// PORTS
//  clk            in   1      system clock; single clock domain
//  reset_n        in   1      synchronous, active-low reset
//  button_raw     in   WIDTH  asynchronous button pins
//  out_port       out  WIDTH  debounced level; connects to the PIO in_port
//  press_pulse    out  WIDTH  1-cycle pulse: bit left IDLE_LEVEL
//  release_pulse  out  WIDTH  1-cycle pulse: bit returned to IDLE_LEVEL
// BEHAVIOUR
//  Interface:
//  - One clock, clk.
//  - Reset is synchronous and active-low on reset_n: sampled only on the rising edge of clk.
//  Reset (reset_n==0 at a clk edge):
//  - sync1, sync2, stable and out_port <= {WIDTH{IDLE_LEVEL}}.
//  - All counters <= 0.
//  - press_pulse and release_pulse <= 0.
//  - Reset mid-count discards the pending change.
//  Per bit i, each rising clk edge:
//  - sync1[i] <= button_raw[i]; sync2[i] <= sync1[i].
//  - sync2==stable: cnt <= 0 (a glitch shorter than the window is fully forgotten).
//  - sync2!=stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//  - sync2!=stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync2; cnt <= 0.
//  - out_port = stable (direct register output, no combinational path from button_raw).
//  Latency:
//  - A level first sampled at edge 1 and held appears on out_port after edge DEBOUNCE_CYCLES+2.
//  - Minimum case DEBOUNCE_CYCLES=1: 3 edges.
//  Width and counter rules:
//  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//  - Bits are fully independent: simultaneous changes on several bits each run their own count.
//  - An input that toggles back before acceptance leaves stable unchanged and emits no pulse.
//  - An input that reverts on the acceptance edge is still accepted: the sample was in the window.
//    The reverse change then needs its own full window.
// CONFIGURATION
//  BUTTON_DEBOUNCE_EVENT_EN defined:
//  - press_pulse[i] high for exactly one cycle, in the first cycle out_port[i]
//    shows ~IDLE_LEVEL; registered as (old stable==IDLE_LEVEL && new stable!=IDLE_LEVEL).
//  - release_pulse[i] is the same on return to IDLE_LEVEL.
//  - A press and a release can never assert on the same bit in the same cycle.
//  BUTTON_DEBOUNCE_EVENT_EN undefined:
//  - press_pulse and release_pulse are tied to 0.
//  - No pulse flops are synthesised; out_port behaviour is identical.
// TESTING  (bench: WIDTH=4, DEBOUNCE_CYCLES=8, IDLE_LEVEL=1)
//  - Reset: hold reset_n=0 3 cycles with button_raw=4'b0000 -> out_port=4'hF, pulses 0.
//  - Clean press: button_raw 4'hF->4'hE, held -> out_port=4'hE exactly 10 edges later.
//    With EVENT_EN, press_pulse=4'h1 for exactly 1 cycle at that same point.
//  - Bounce: bit0 toggles 0/1 every 3 cycles for 30 cycles, then holds 0 -> out_port stays 4'hF,
//    then 4'hE 10 edges after the final toggle; exactly one press_pulse.
//  - Glitch: bit2 low for 7 cycles then high -> out_port stays 4'hF; no pulses.
//  - Independent bits: bit1 low at t=0, bit3 low at t=4 -> out_port 4'hD at t=10, 4'h5 at t=14.
//  - Reset mid-count: press bit0, assert reset_n=0 at count 5, release reset with input still low
//    -> out_port=4'hF until 10 edges after reset release, then 4'hE.

Source files
------------

// File: rtl/nios_accelerometer_button_debounce.sv
// Push-button conditioner: two-flop synchroniser plus a per-bit debounce counter.
// Define BUTTON_DEBOUNCE_EVENT_EN to build the registered press/release pulse outputs.
module nios_accelerometer_button_debounce #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter logic        IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] button_raw,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0]            sync1_q, sync1_d;
    logic [WIDTH-1:0]            sync2_q, sync2_d;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counter restarts whenever the synchronised input agrees with the accepted level.
    always_comb begin
        sync1_d  = button_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q  <= IDLE_VEC;
            sync2_q  <= IDLE_VEC;
            stable_q <= IDLE_VEC;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_port = stable_q;

`ifdef BUTTON_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;

    // Pulses are registered alongside stable so they line up with the new out_port level.
    always_comb begin
        press_d   = (stable_q ^ stable_d) & ~(stable_q ^ IDLE_VEC);
        release_d = (stable_q ^ stable_d) & ~(stable_d ^ IDLE_VEC);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`else
    assign press_pulse   = '0;
    assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_nios_accelerometer_button_debounce.sv
// Scoreboard bench for the button debouncer (WIDTH=4, DEBOUNCE_CYCLES=8, IDLE_LEVEL=1).
module tb_nios_accelerometer_button_debounce;

    logic       clk;
    logic       reset_n;
    logic [3:0] button_raw;
    logic [3:0] out_port;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] press;
        logic [3:0] rel;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    nios_accelerometer_button_debounce #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (3),
        .IDLE_LEVEL     (1'b1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .button_raw   (button_raw),
        .out_port     (out_port),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] ev(input logic [3:0] x);
`ifdef BUTTON_DEBOUNCE_EVENT_EN
        return x;
`else
        return 4'h0;
`endif
    endfunction

    function automatic exp_t mk(input logic [3:0] o, input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        e.out   = o;
        e.press = ev(p);
        e.rel   = ev(r);
        return e;
    endfunction

    // Apply one cycle of stimulus, queue what the outputs must be after the edge.
    task automatic drive_cycle(input logic [3:0] raw, input logic rst, input exp_t e);
        button_raw = raw;
        reset_n    = rst;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'h0, 1'b0, mk(4'hF, 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL reset c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 4; c++) begin
            drive_cycle(4'hF, 1'b1, mk(4'hF, 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL idle c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    // A held change appears on the 10th edge after it is first sampled.
    task automatic test_clean_press();
        exp_t e;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hE, 1'b1, mk((c >= 9) ? 4'hE : 4'hF, (c == 9) ? 4'h1 : 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL clean_press c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hF, 1'b1, mk((c >= 9) ? 4'hF : 4'hE, 4'h0, (c == 9) ? 4'h1 : 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL clean_release c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        exp_t       e;
        logic [3:0] raw;
        int         presses = 0;
        for (int c = 0; c < 42; c++) begin
            raw = (c < 30 && ((c / 3) % 2 == 1)) ? 4'hF : 4'hE;
            drive_cycle(raw, 1'b1, mk((c >= 39) ? 4'hE : 4'hF, (c == 39) ? 4'h1 : 4'h0, 4'h0));
            e = sb.pop_front();
            if (press_pulse[0] === 1'b1) presses++;
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL bounce c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        total_cnt++;
        if (presses !== ((ev(4'h1) == 4'h1) ? 1 : 0))
            $display("FAIL bounce_press_count: got %0d want %0d", presses,
                     (ev(4'h1) == 4'h1) ? 1 : 0);
        else pass_cnt++;
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hF, 1'b1, mk((c >= 9) ? 4'hF : 4'hE, 4'h0, (c == 9) ? 4'h1 : 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL bounce_release c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    // Seven low cycles is one short of the window and must be forgotten.
    task automatic test_glitch();
        exp_t e;
        for (int c = 0; c < 22; c++) begin
            drive_cycle((c < 7) ? 4'hB : 4'hF, 1'b1, mk(4'hF, 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL glitch c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    task automatic test_independent();
        exp_t       e;
        logic [3:0] raw;
        logic [3:0] o;
        for (int c = 0; c < 16; c++) begin
            raw = (c >= 4) ? 4'h5 : 4'hD;
            o   = (c >= 13) ? 4'h5 : ((c >= 9) ? 4'hD : 4'hF);
            drive_cycle(raw, 1'b1,
                        mk(o, (c == 9) ? 4'h2 : ((c == 13) ? 4'h8 : 4'h0), 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL independent c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hF, 1'b1, mk((c >= 9) ? 4'hF : 4'h5, 4'h0, (c == 9) ? 4'hA : 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL independent_release c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    // Input reverts exactly on the acceptance edge: press accepted, release needs a full window.
    task automatic test_revert_on_accept();
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            drive_cycle((c < 8) ? 4'hE : 4'hF, 1'b1,
                        mk((c >= 9 && c < 17) ? 4'hE : 4'hF,
                           (c == 9) ? 4'h1 : 4'h0, (c == 17) ? 4'h1 : 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL revert_on_accept c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_count();
        exp_t e;
        for (int c = 0; c < 7; c++) begin
            drive_cycle(4'hE, 1'b1, mk(4'hF, 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL reset_mid_pre c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 2; c++) begin
            drive_cycle(4'hE, 1'b0, mk(4'hF, 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL reset_mid_hold c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hE, 1'b1, mk((c >= 9) ? 4'hE : 4'hF, (c == 9) ? 4'h1 : 4'h0, 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL reset_mid_post c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'hF, 1'b1, mk((c >= 9) ? 4'hF : 4'hE, 4'h0, (c == 9) ? 4'h1 : 4'h0));
            e = sb.pop_front();
            total_cnt++;
            if (out_port !== e.out || press_pulse !== e.press || release_pulse !== e.rel)
                $display("FAIL reset_mid_release c=%0d: got out=%h p=%h r=%h want out=%h p=%h r=%h",
                         c, out_port, press_pulse, release_pulse, e.out, e.press, e.rel);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        button_raw = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_independent();
        test_revert_on_accept();
        test_reset_mid_count();
        total_cnt++;
        if (sb.size() !== 0)
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
